shift_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the ALU shift path: accepts one shift op (SLL/SRL/SRA/ROR)
//  on a valid/ready input port and iterates a narrow step shifter STEP bits per cycle.

---
 rtl/alu_shift_pkg.sv | 21 ++
 rtl/shift_step.sv | 30 +++
 rtl/shift_seq_ctrl.sv | 105 ++++++++++
 tb/tb_shift_seq_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_shift_pkg.sv
// Shared definitions for the ALU shift path: op codes, sequencer states and
// the per-cycle step-size helper.
package alu_shift_pkg;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Bits to shift this cycle: the smaller of what remains and the step width.
   function automatic logic [3:0] step_amt(input logic [4:0] rem, input logic [4:0] step);
      return (rem < step) ? rem[3:0] : step[3:0];
   endfunction

endpackage

// File: rtl/shift_step.sv
// Narrow combinational shifter: moves data by k bits (0..STEP) in the
// direction and fill mode selected by op.
module shift_step
   import alu_shift_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] data,
   input  logic [1:0]       op,
   input  logic [3:0]       k,
   output logic [WIDTH-1:0] data_out
);

   localparam int SW = $clog2(WIDTH) + 1;

   logic [SW-1:0] rot_lsh;

   always_comb begin
      rot_lsh = SW'(WIDTH) - SW'(k);
      case (op)
         OP_SLL:  data_out = data << k;
         OP_SRL:  data_out = data >> k;
         OP_SRA:  data_out = WIDTH'($signed(data) >>> k);
         // k==0 gives a full-width left shift, which yields zero and leaves data intact
         OP_ROR:  data_out = (data >> k) | (data << rot_lsh);
         default: data_out = data;
      endcase
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: accepts one op on a valid/ready port, iterates
// shift_step STEP bits per cycle and returns the result on a valid/ready port.
module shift_seq_ctrl
   import alu_shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             busy
);

   localparam logic [4:0] STEP_W = 5'(STEP);

   state_e           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [4:0]       rem_q, rem_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [3:0]       k_amt;
   logic [WIDTH-1:0] step_out;
   logic             unused_b;

   assign unused_b = ^b[WIDTH-1:5];

   shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .data     (data_q),
      .op       (op_q),
      .k        (k_amt),
      .data_out (step_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= OP_SLL;
         data_q  <= '0;
         rem_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         res_q   <= res_d;
      end
   end

   // res is loaded only on entry to DONE so it holds through IDLE and the next op
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      data_d  = data_q;
      rem_d   = rem_q;
      res_d   = res_q;
      k_amt   = step_amt(rem_q, STEP_W);
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               op_d   = op;
               data_d = a;
               rem_d  = b[4:0];
               if (b[4:0] == 5'd0) begin
                  state_d = ST_DONE;
                  res_d   = a;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            data_d = step_out;
            rem_d  = rem_q - {1'b0, k_amt};
            if (rem_q == {1'b0, k_amt}) begin
               state_d = ST_DONE;
               res_d   = step_out;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
   end

   assign res = res_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: directed ops push expected result and
// latency; a negedge monitor pops and compares on each output handshake.
module tb_shift_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] res;
   logic        busy;

   typedef struct {
      logic [31:0] res;
      int unsigned lat;
      int unsigned acc;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned ov_start = 0;
   logic        ov_prev = 1'b0;

   shift_seq_ctrl #(
      .WIDTH (32),
      .STEP  (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: cycle invariants plus scoreboard pop on each output handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         check("ov_ir_exclusive", {31'd0, out_valid && in_ready}, 32'd0);
         check("busy_not_ready", {31'd0, busy}, {31'd0, !in_ready});
         if (out_valid && !ov_prev) ov_start = cyc;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_result: got res 0x%08h expected no output", res);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("result", res, e.res);
               check("latency", ov_start - e.acc, e.lat);
            end
         end
         ov_prev = out_valid;
      end else begin
         ov_prev = 1'b0;
      end
   end

   // Called at posedge+#1; returns at posedge+#1 one edge after the accept.
   task automatic send(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] exp, input int unsigned lat, input bit push,
                       output int unsigned waited);
      in_valid = 1'b1;
      op = o;
      a = aa;
      b = bb;
      waited = 0;
      while (!in_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
      end else if (push) begin
         sb.push_back('{res: exp, lat: lat, acc: cyc});
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = 2'($urandom);
      a = $urandom;
      b = $urandom;
   endtask

   task automatic wait_done();
      int unsigned n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0 || !in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
      end
   endtask

   task automatic run(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                      input logic [31:0] exp, input int unsigned lat);
      int unsigned w;
      send(o, aa, bb, exp, lat, 1'b1, w);
      wait_done();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned w;
      int unsigned n;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      op = 2'b00;
      a = '0;
      b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_res", res, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run(2'b01, 32'd11242412, 32'd2, 32'd2810603, 2);
      check("res_hold_idle", res, 32'd2810603);
      run(2'b01, 32'd32143513, 32'd7, 32'd251121, 3);
      run(2'b01, 32'd93152513, 32'd5, 32'd2911016, 3);
      run(2'b10, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 9);
      run(2'b00, 32'h0000_0001, 32'd31, 32'h8000_0000, 9);
      run(2'b11, 32'h0000_0001, 32'd1, 32'h8000_0000, 2);
      run(2'b11, 32'h1234_5678, 32'd12, 32'h6781_2345, 4);
      run(2'b10, 32'hF000_000F, 32'd6, 32'hFFC0_0000, 3);
      run(2'b10, 32'h7000_0000, 32'd4, 32'h0700_0000, 2);
      run(2'b01, 32'd1513242, 32'd37, 32'd47288, 3);
      run(2'b01, 32'd1513242, 32'd0, 32'd1513242, 1);

      // Stall the consumer in DONE, then release with a new request waiting.
      out_ready = 1'b0;
      send(2'b01, 32'd11242412, 32'd2, 32'd2810603, 2, 1'b1, w);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("stall_reached_done", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("stall_res", res, 32'd2810603);
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      send(2'b01, 32'd93152513, 32'd5, 32'd2911016, 3, 1'b1, w);
      check("accept_after_done", w, 32'd1);
      wait_done();

      // Reset in the middle of SHIFT drops the op.
      send(2'b01, 32'd73412343, 32'd9, 32'd0, 4, 1'b0, w);
      check("mid_busy", {31'd0, busy}, 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_res", res, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("dropped_no_output", {31'd0, out_valid}, 32'd0);
      end
      run(2'b01, 32'd72345233, 32'd7, 32'd565197, 3);

      repeat (2) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
